if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  hazard unit hold; freezes PC and IF/ID.
REQ-006 branch_taken  input  1  branch resolved taken; redirect to branch_target.
REQ-007 branch_target  input  32  branch destination byte address.
REQ-008 jump  input  1  jump decoded; redirect to jump_target.
REQ-009 jump_target  input  32  jump destination byte address.
REQ-010 imem_addr  output  32  byte address to Instruction_Mem; equals current PC.
REQ-011 imem_instr  input  32  instruction word from Instruction_Mem, valid combinationally in the same cycle as imem_addr.
REQ-012 if_id_instr  output  32  registered instruction for decode.
REQ-013 if_id_pc4  output  32  registered PC+4 of if_id_instr.
REQ-014 if_id_valid  output  1  high when if_id_instr is a real fetched instruction, low for a bubble.
REQ-015 fetch_count  output  32  count of instructions accepted into IF/ID.

Function
REQ-016 imem_addr SHALL be driven directly from the PC register, with no combinational path from any input.
REQ-017 Next-PC priority SHALL be: branch_taken > jump > stall > sequential (PC+4).
REQ-018 Redirect targets SHALL load with bits [1:0] forced to 2'b00.
REQ-019 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-020 Sequential cycle (no stall, no redirect): PC<=PC+4; IF/ID<= {imem_instr, PC+4, valid=1}; fetch_count increments.
REQ-021 Stall without redirect: PC, if_id_instr, if_id_pc4, if_id_valid and fetch_count SHALL all hold.
REQ-022 Redirect (branch_taken or jump), with or without stall: PC<=target; IF/ID<= {NOP_INSTR, 32'h0, valid=0}; fetch_count holds.
REQ-023 Branch and jump asserted together: the branch target wins and only one bubble is inserted.
REQ-024 Fetch latency: the instruction at address A SHALL appear on if_id_instr exactly one clock after imem_addr=A, provided that cycle is neither stalled nor redirected.
REQ-025 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.

Reset
REQ-026 rst_n low SHALL immediately, without waiting for clk, set PC=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0 and fetch_count=0.
REQ-027 Reset asserted mid-stall or mid-redirect SHALL discard the pending operation.
REQ-028 On the first rising edge after rst_n deasserts, the block SHALL fetch from RESET_PC.

Structure
REQ-029 Package mips_pkg SHALL hold XLEN=32, RESET_PC and NOP_INSTR; the parameter defaults SHALL come from it.
REQ-030 One sub-module, pc_reg, SHALL hold the PC register with next-PC select; the IF/ID register and counter stay in if_stage.

Verification
REQ-031 Free run from reset, stall=0 -> imem_addr 0,4,8,...,52 on successive cycles; if_id_pc4 trails by one cycle (4,8,...); fetch_count=14 after 14 fetches.
REQ-032 stall high for 3 cycles with PC=16 -> imem_addr stays 16 and IF/ID holds the word from address 12 (pc4=16); after release, address 16 is fetched.
REQ-033 branch_taken with target 32'h0000_0043 at PC=20 -> next imem_addr=32'h40; if_id_valid=0 for one cycle; fetch_count unchanged that cycle.
REQ-034 branch_taken=1 and jump=1 with targets 0x100 and 0x200 -> imem_addr=0x100; single bubble.
REQ-035 PC preset to 32'hFFFF_FFFC by redirect, then free run -> next imem_addr=0; if_id_pc4=0.
REQ-036 rst_n pulsed low between clock edges at PC=28 -> outputs take their reset values immediately; after release, fetch restarts at 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end.
//   XLEN      : datapath width
//   RESET_PC  : default PC loaded on reset
//   NOP_INSTR : bubble word (sll $0,$0,0)
//   pc_sel_e  : next-PC source selector used by pc_reg
//   align_word: clears the byte-offset bits of a redirect target
package mips_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        PcSeq,
        PcHold,
        PcBranch,
        PcJump
    } pc_sel_e;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with next-PC selection.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   stall_i           : hold the PC
//   branch_taken_i    : redirect to branch_target_i (highest priority)
//   branch_target_i   : branch destination byte address
//   jump_i            : redirect to jump_target_i
//   jump_target_i     : jump destination byte address
//   pc_o              : current PC (straight from the register)
//   pc_plus4_o        : PC + 4, wrapping modulo 2^32
//   redirect_o        : a branch or jump redirect is taking effect this cycle
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        redirect_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    pc_sel_e     sel;

    // Carry out of bit 31 is dropped, so 0xFFFF_FFFC + 4 wraps to 0.
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        sel = PcSeq;
        if (branch_taken_i) begin
            sel = PcBranch;
        end else if (jump_i) begin
            sel = PcJump;
        end else if (stall_i) begin
            sel = PcHold;
        end
    end

    always_comb begin
        pc_d = pc_plus4;
        unique case (sel)
            PcSeq:    pc_d = pc_plus4;
            PcHold:   pc_d = pc_q;
            PcBranch: pc_d = align_word(branch_target_i);
            PcJump:   pc_d = align_word(jump_target_i);
            default:  pc_d = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4;
    assign redirect_o = (sel == PcBranch) || (sel == PcJump);

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, instruction-memory address, IF/ID pipeline
// register and accepted-instruction counter.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   stall                       : freeze PC and IF/ID
//   branch_taken, branch_target : taken-branch redirect
//   jump, jump_target           : jump redirect
//   imem_addr                   : fetch address (the PC register)
//   imem_instr                  : instruction word for imem_addr, same cycle
//   if_id_instr, if_id_pc4      : registered instruction and its PC+4
//   if_id_valid                 : low when IF/ID holds a bubble
//   fetch_count                 : instructions accepted into IF/ID
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect;

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall),
        .branch_taken_i (branch_taken),
        .branch_target_i(branch_target),
        .jump_i         (jump),
        .jump_target_i  (jump_target),
        .pc_o           (pc),
        .pc_plus4_o     (pc_plus4),
        .redirect_o     (redirect)
    );

    // Redirect flushes the word being fetched even when stalled; a plain
    // stall holds everything.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        count_d = count_q;
        if (redirect) begin
            instr_d = NOP_INSTR;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end else if (!stall) begin
            instr_d = imem_instr;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            count_q <= 32'h0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign imem_addr   = pc;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_cnt;

    if_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .fetch_count  (fetch_count)
    );

    // Instruction memory: each word is a fixed function of its address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    assign imem_instr = word_at(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                              input logic valid, input logic [31:0] cnt);
        check({tag, ".instr"}, if_id_instr, instr);
        check({tag, ".pc4"}, if_id_pc4, pc4);
        check({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, valid});
        check({tag, ".count"}, fetch_count, cnt);
    endtask

    initial begin
        rst_n         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        exp_cnt       = 32'd0;

        // Reset state
        #2;
        check("rst.addr", imem_addr, 32'h0);
        check_ifid("rst", 32'h0, 32'h0, 1'b0, 32'd0);
        #1 rst_n = 1'b1;

        // Free run 0..52
        for (int i = 0; i < 14; i++) begin
            check("run.addr", imem_addr, 32'(4 * i));
            tick();
            exp_cnt = exp_cnt + 1;
            check_ifid("run", word_at(32'(4 * i)), 32'(4 * i + 4), 1'b1, exp_cnt);
        end
        check("run.count14", fetch_count, 32'd14);

        // Jump to 12 then one sequential fetch, leaving PC=16, IF/ID=word(12)
        jump = 1'b1; jump_target = 32'd12;
        tick();
        check("j12.addr", imem_addr, 32'd12);
        check_ifid("j12", 32'h0, 32'h0, 1'b0, exp_cnt);
        jump = 1'b0;
        tick();
        exp_cnt = exp_cnt + 1;
        check("seq12.addr", imem_addr, 32'd16);
        check_ifid("seq12", word_at(32'd12), 32'd16, 1'b1, exp_cnt);

        // Stall 3 cycles at PC=16
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.addr", imem_addr, 32'd16);
            check_ifid("stall", word_at(32'd12), 32'd16, 1'b1, exp_cnt);
        end
        stall = 1'b0;
        tick();
        exp_cnt = exp_cnt + 1;
        check("unstall.addr", imem_addr, 32'd20);
        check_ifid("unstall", word_at(32'd16), 32'd20, 1'b1, exp_cnt);

        // Branch at PC=20 to unaligned 0x43
        branch_taken = 1'b1; branch_target = 32'h0000_0043;
        tick();
        check("br.addr", imem_addr, 32'h40);
        check_ifid("br", 32'h0, 32'h0, 1'b0, exp_cnt);
        branch_taken = 1'b0;
        tick();
        exp_cnt = exp_cnt + 1;
        check("br_after.addr", imem_addr, 32'h44);
        check_ifid("br_after", word_at(32'h40), 32'h44, 1'b1, exp_cnt);

        // Branch and jump together: branch wins, one bubble
        branch_taken = 1'b1; branch_target = 32'h100;
        jump = 1'b1; jump_target = 32'h200;
        tick();
        check("brj.addr", imem_addr, 32'h100);
        check_ifid("brj", 32'h0, 32'h0, 1'b0, exp_cnt);
        branch_taken = 1'b0; jump = 1'b0;
        tick();
        exp_cnt = exp_cnt + 1;
        check("brj_after.addr", imem_addr, 32'h104);
        check_ifid("brj_after", word_at(32'h100), 32'h104, 1'b1, exp_cnt);

        // Jump while stalled: redirect still wins
        stall = 1'b1; jump = 1'b1; jump_target = 32'h300;
        tick();
        check("sj.addr", imem_addr, 32'h300);
        check_ifid("sj", 32'h0, 32'h0, 1'b0, exp_cnt);
        stall = 1'b0;

        // Jump to 0xFFFF_FFFF (aligns to 0xFFFF_FFFC), then wrap
        jump_target = 32'hFFFF_FFFF;
        tick();
        check("wrap.addr", imem_addr, 32'hFFFF_FFFC);
        jump = 1'b0;
        tick();
        exp_cnt = exp_cnt + 1;
        check("wrap_after.addr", imem_addr, 32'h0);
        check_ifid("wrap_after", word_at(32'hFFFF_FFFC), 32'h0, 1'b1, exp_cnt);

        // Reach PC=28, then reset between edges with a redirect+stall pending
        jump = 1'b1; jump_target = 32'd28;
        tick();
        check("j28.addr", imem_addr, 32'd28);
        stall = 1'b1; jump_target = 32'h500;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst.addr", imem_addr, 32'h0);
        check_ifid("mid_rst", 32'h0, 32'h0, 1'b0, 32'd0);
        #2;
        rst_n = 1'b1; stall = 1'b0; jump = 1'b0;
        check("restart.addr0", imem_addr, 32'h0);
        tick();
        check("restart.addr", imem_addr, 32'd4);
        check_ifid("restart", word_at(32'h0), 32'd4, 1'b1, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
